// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI-style serial front end for a small RAM.
// Receives ADDR_SIZE+2 bit command words (2-bit opcode + payload), MSB first,
// one bit per clk while SS_n is low, and forwards them on rx_data/rx_valid.
// A read-data command waits for tx_valid and then shifts tx_data out on MISO.
// Optional build macro: CMD_ERR_EN adds opcode checking and the cmd_err port.
//
// state     | meaning
// IDLE      | waiting for SS_n sampled low
// CHK_CMD   | sampling word MSB, which selects the command path
// WRITE     | shifting a write command (address or data) word
// READ_ADD  | shifting a read-address word; completion sets rd_addr_seen
// READ_DATA | shifting a read-data word, then waiting for tx_valid and driving MISO
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef CMD_ERR_EN
  ,
  output logic                 cmd_err
`endif
);

  localparam int W  = ADDR_SIZE + 2;
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         bit_cnt;
  logic [W-2:0]          shift_reg;
  logic [W-1:0]          word_nxt;
  logic                  rd_addr_seen;
  logic                  rd_wait;
  logic [ADDR_SIZE-1:0]  tx_shift;
  logic [TW-1:0]         tx_cnt;
  logic                  op_ok;
  logic                  shifting;
  logic                  last_bit;

  // Word as it stands once the current MOSI bit is included.
  assign word_nxt = {shift_reg, MOSI};
  assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign last_bit = shifting && (bit_cnt == CW'(W - 1));

`ifdef CMD_ERR_EN
  // Opcode must agree with the path chosen by the word MSB and rd_addr_seen.
  always_comb begin
    op_ok = 1'b0;
    case (state)
      WRITE:     op_ok = (word_nxt[W-1] == 1'b0);
      READ_ADD:  op_ok = (word_nxt[W-1:W-2] == 2'b10);
      READ_DATA: op_ok = (word_nxt[W-1:W-2] == 2'b11);
      default:   op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  // MISO is only live while tx bits remain in the READ_DATA shift phase.
  assign MISO = (!rst && (state == READ_DATA) && (tx_cnt != '0)) ? tx_shift[ADDR_SIZE-1] : 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; SS_n high returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Receive shifter, word hand-off, read-data capture and MISO shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      rd_wait      <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
`ifdef CMD_ERR_EN
      cmd_err      <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef CMD_ERR_EN
      cmd_err  <= 1'b0;
`endif
      if (SS_n) begin
        // Abort: drop any partial word and pending read; rd_addr_seen survives.
        bit_cnt   <= '0;
        shift_reg <= '0;
        rd_wait   <= 1'b0;
        tx_shift  <= '0;
        tx_cnt    <= '0;
      end else begin
        if (state == CHK_CMD) begin
          shift_reg <= {{(W-2){1'b0}}, MOSI};
          bit_cnt   <= CW'(1);
        end else if (shifting && (bit_cnt != CW'(W))) begin
          shift_reg <= word_nxt[W-2:0];
          bit_cnt   <= bit_cnt + CW'(1);
          if (last_bit) begin
            if (op_ok) begin
              rx_data  <= word_nxt;
              rx_valid <= 1'b1;
              if (state == READ_ADD) rd_addr_seen <= 1'b1;
            end
`ifdef CMD_ERR_EN
            else begin
              cmd_err <= 1'b1;
            end
`endif
          end
        end

        if (state == READ_DATA) begin
          // The wait for RAM data opens the cycle after the accepted word's strobe.
          if (rx_valid) rd_wait <= 1'b1;
          if (rd_wait && tx_valid) begin
            tx_shift     <= tx_data;
            tx_cnt       <= TW'(ADDR_SIZE);
            rd_wait      <= 1'b0;
            rd_addr_seen <= 1'b0;
          end else if (tx_cnt != '0) begin
            tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
            tx_cnt   <= tx_cnt - TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl (ADDR_SIZE = 8). Stimulus pushes the
// expected word/error event with its expected cycle; a monitor pops on every
// rx_valid (or cmd_err when CMD_ERR_EN is defined) and compares.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef CMD_ERR_EN
  logic       cmd_err;
`endif

  spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef CMD_ERR_EN
    ,
    .cmd_err  (cmd_err)
`endif
  );

  typedef struct {
    int         kind;   // 1 = rx_valid word, 2 = cmd_err pulse
    logic [9:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected event for every observed strobe.
  initial begin
    logic prev_valid;
    logic err_now;
    int   kind;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      err_now = 1'b0;
`ifdef CMD_ERR_EN
      err_now = cmd_err;
`endif
      if (rx_valid) begin
        n_checks++;
        if (prev_valid) begin
          n_errors++;
          $display("FAIL rx_valid_back_to_back: got 2 consecutive cycles required 1 (cycle %0d)", cyc);
        end
      end
      if (rx_valid || err_now) begin
        kind = rx_valid ? 1 : 2;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event: got kind %0d data %0h, required none (cycle %0d)", kind, rx_data, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != kind || e.cyc != cyc || (kind == 1 && e.data !== rx_data)) begin
            n_errors++;
            $display("FAIL event: got kind %0d data %0h cycle %0d, required kind %0d data %0h cycle %0d",
                     kind, rx_data, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
      prev_valid = rx_valid;
    end
  end

  // Sends nbits of w MSB first after one SS_n-low lead-in cycle; kind 0 expects no event.
  task automatic send_word(input logic [9:0] w, input int nbits, input int extra,
                           input bit keep_low, input int kind);
    exp_t e;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = w[9-i];
    end
    if (kind != 0) begin
      e.kind = kind;
      e.data = w;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      MOSI = ~MOSI;
    end
    if (!keep_low) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called right after a READ_DATA word: supplies d on tx_valid and checks
  // MISO; stop_at > 0 asserts rst while the stop_at-th bit is on MISO.
  task automatic read_back(input logic [7:0] d, input int stop_at);
    @(negedge clk);              // rx_valid cycle
    @(negedge clk);              // wait phase open
    chk("miso_before_capture", 32'(MISO), 32'h0);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);              // captured; keep tx_valid high with other data
    tx_data = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (i != 7) @(negedge clk);
      chk("miso_bit", 32'(MISO), 32'(d[i]));
      if (stop_at > 0 && (8 - i) == stop_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        rst      = 1'b0;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    chk("miso_after_word", 32'(MISO), 32'h0);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("miso_idle_tail", 32'(MISO), 32'h0);
    chk("rd_addr_seen_cleared", 32'(dut.rd_addr_seen), 32'h0);
    SS_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic exp_seen;
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_miso", 32'(MISO), 32'h0);
    chk("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    send_word(10'h011, 10, 0, 0, 1);
    send_word(10'h1A5, 10, 0, 0, 1);
    send_word(10'h211, 10, 0, 0, 1);
    chk("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'h1);

    // Partial word aborted after 5 bits: no strobe, rd_addr_seen kept.
    send_word(10'h3FF, 5, 0, 0, 0);
    chk("abort_rd_addr_seen_kept", 32'(dut.rd_addr_seen), 32'h1);
    chk("abort_miso", 32'(MISO), 32'h0);

    send_word(10'h300, 10, 0, 1, 1);
    read_back(8'hFF, 0);

`ifdef CMD_ERR_EN
    send_word(10'h311, 10, 0, 0, 2);
    exp_seen = 1'b0;
`else
    send_word(10'h311, 10, 0, 0, 1);
    exp_seen = 1'b1;
`endif
    chk("opcode_check_rd_addr_seen", 32'(dut.rd_addr_seen), 32'(exp_seen));

    send_word(10'h211, 10, 0, 0, 1);
    send_word(10'h300, 10, 0, 1, 1);
    read_back(8'hA5, 3);

    send_word(10'h0C3, 10, 0, 0, 1);
    send_word(10'h055, 10, 4, 0, 1);   // trailing bits in same window ignored

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
